// File: rtl/cpu_pipeline_fwd_pkg.sv
// Shared types for the five-stage pipelined core: opcodes, ALU and
// forwarding selects, pipe-register control payloads and the decoder.
// Datapath-width fields (PC, operands, results) depend on module
// parameters and are carried beside these structs in the top level.
package cpu_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned IMM_W     = 20;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_B    = 4'h8,
        OP_BEQ  = 4'h9,
        OP_BNE  = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        alu_op_e              alu_op;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
        logic [REG_IDX_W-1:0] dst;
        logic                 use_ra;
        logic                 use_rb;
        logic                 use_imm;
        logic                 we;
        logic                 is_load;
        logic                 is_store;
        logic                 is_b;
        logic                 is_beq;
        logic                 is_bne;
        logic                 is_halt;
        logic [IMM_W-1:0]     imm;
    } id_ex_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic                 we;
        logic                 is_load;
        logic                 is_store;
    } ex_mem_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic                 we;
    } mem_wb_t;

    // Instruction decode; reserved opcodes fall through as NOP and a
    // write to r0 is dropped here so it never acts as a hazard source.
    function automatic id_ex_t decode(input logic [INSTR_W-1:0] instr);
        id_ex_t  d;
        opcode_e op;
        d      = '0;
        op     = opcode_e'(instr[31:28]);
        d.ra   = instr[27:24];
        d.rb   = instr[23:20];
        d.imm  = instr[19:0];
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                d.use_ra = 1'b1;
                d.use_rb = 1'b1;
                d.we     = 1'b1;
                d.dst    = instr[19:16];
                case (op)
                    OP_SUB:  d.alu_op = ALU_SUB;
                    OP_AND:  d.alu_op = ALU_AND;
                    OP_OR:   d.alu_op = ALU_OR;
                    default: d.alu_op = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_LDR: begin
                d.use_ra  = 1'b1;
                d.use_imm = 1'b1;
                d.we      = 1'b1;
                d.dst     = instr[23:20];
                d.is_load = (op == OP_LDR);
            end
            OP_STR: begin
                d.use_ra   = 1'b1;
                d.use_rb   = 1'b1;
                d.use_imm  = 1'b1;
                d.is_store = 1'b1;
            end
            OP_B:    d.is_b = 1'b1;
            OP_BEQ: begin
                d.use_ra = 1'b1;
                d.use_rb = 1'b1;
                d.is_beq = 1'b1;
            end
            OP_BNE: begin
                d.use_ra = 1'b1;
                d.use_rb = 1'b1;
                d.is_bne = 1'b1;
            end
            OP_HALT: d.is_halt = 1'b1;
            default: ;
        endcase
        d.we = d.we && (d.dst != '0);
        return d;
    endfunction

endpackage

// File: rtl/cpu_pipeline_fwd_if.sv
// Memory-side bus of the core: instruction fetch port, data port and
// the halted status.
//   master: the core (drives addresses, store data/strobe, halted_o)
//   slave : the memory wrapper (drives instruction and load data)
interface cpu_pipeline_fwd_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic [31:0]       inst_mem_data_i;
    logic [ADDR_W-1:0] inst_mem_address_o;
    logic [DATA_W-1:0] data_mem_out_data_i;
    logic [ADDR_W-1:0] data_mem_address_o;
    logic [DATA_W-1:0] data_mem_in_data_o;
    logic              data_mem_WE_o;
    logic              halted_o;

    modport master (
        input  inst_mem_data_i,
        input  data_mem_out_data_i,
        output inst_mem_address_o,
        output data_mem_address_o,
        output data_mem_in_data_o,
        output data_mem_WE_o,
        output halted_o
    );

    modport slave (
        output inst_mem_data_i,
        output data_mem_out_data_i,
        input  inst_mem_address_o,
        input  data_mem_address_o,
        input  data_mem_in_data_o,
        input  data_mem_WE_o,
        input  halted_o
    );
endinterface

// File: rtl/cpu_pipeline_fwd_hazard.sv
// hazard_unit: combinational forwarding selects and stall/flush/halt
// controls for the pipeline.
//   id_*  : source indices/use flags of the instruction in ID
//   ex_*  : sources, destination and load flag of the instruction in EX
//   mem_* / wb_* : destinations of the instructions in MEM and WB
//   br_taken, ex_halt : redirect events resolved in EX
//   fwd_a_c/fwd_b_c : EX operand sources; stall_c/flush_c/halt_c controls
module hazard_unit
    import cpu_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic [REG_IDX_W-1:0] id_ra,
    input  logic [REG_IDX_W-1:0] id_rb,
    input  logic                 id_use_ra,
    input  logic                 id_use_rb,
    input  logic [REG_IDX_W-1:0] ex_ra,
    input  logic [REG_IDX_W-1:0] ex_rb,
    input  logic                 ex_use_ra,
    input  logic                 ex_use_rb,
    input  logic [REG_IDX_W-1:0] ex_dst,
    input  logic                 ex_we,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] mem_dst,
    input  logic                 mem_we,
    input  logic                 mem_is_load,
    input  logic [REG_IDX_W-1:0] wb_dst,
    input  logic                 wb_we,
    input  logic                 br_taken,
    input  logic                 ex_halt,
    output fwd_sel_e             fwd_a_c,
    output fwd_sel_e             fwd_b_c,
    output logic                 stall_c,
    output logic                 flush_c,
    output logic                 halt_c
);

    function automatic logic hits(input logic [REG_IDX_W-1:0] src,
                                  input logic                 use_src,
                                  input logic [REG_IDX_W-1:0] dst,
                                  input logic                 we);
        return use_src && we && (dst != '0) && (src == dst);
    endfunction

    // MEM wins over WB; a load in MEM never forwards (interlock covers it).
    function automatic fwd_sel_e pick(input logic [REG_IDX_W-1:0] src,
                                      input logic                 use_src);
        fwd_sel_e s;
        s = FWD_REG;
        if (hits(src, use_src, mem_dst, mem_we) && !mem_is_load) begin
            s = FWD_MEM;
        end else if (hits(src, use_src, wb_dst, wb_we)) begin
            s = FWD_WB;
        end
        return s;
    endfunction

    logic ex_dep;
    logic mem_dep;
    logic stall_req;

    // Stall/flush arbitration: a redirect in EX always overrides a stall.
    always_comb begin : ctrl
        fwd_a_c   = FWD_REG;
        fwd_b_c   = FWD_REG;
        ex_dep    = hits(id_ra, id_use_ra, ex_dst, ex_we) ||
                    hits(id_rb, id_use_rb, ex_dst, ex_we);
        mem_dep   = hits(id_ra, id_use_ra, mem_dst, mem_we) ||
                    hits(id_rb, id_use_rb, mem_dst, mem_we);
        if (FORWARD_EN) begin
            fwd_a_c   = pick(ex_ra, ex_use_ra);
            fwd_b_c   = pick(ex_rb, ex_use_rb);
            stall_req = ex_dep && ex_is_load;
        end else begin
            stall_req = ex_dep || mem_dep;
        end
        halt_c  = ex_halt;
        flush_c = br_taken || ex_halt;
        stall_c = stall_req && !flush_c;
    end

endmodule

// File: rtl/cpu_pipeline_fwd.sv
// cpu_pipeline_fwd: five-stage IF/ID/EX/MEM/WB core with operand
// forwarding, load-use interlock, taken-branch flush and HALT.
//   CLK, RST_N : clock, asynchronous active-low reset
//   mem_if     : instruction/data memory bus (same-cycle read data),
//                store strobe/data/address from EX/MEM, halted_o
module cpu_pipeline_fwd
    import cpu_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter bit                FORWARD_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    cpu_pipeline_fwd_if.master mem_if
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    if_id_t            if_id_q, if_id_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    id_ex_t            id_ex_q, id_ex_d;
    logic [ADDR_W-1:0] id_ex_pc_q, id_ex_pc_d;
    logic [DATA_W-1:0] id_ex_a_q, id_ex_a_d, id_ex_b_q, id_ex_b_d;
    ex_mem_t           ex_mem_q, ex_mem_d;
    logic [DATA_W-1:0] ex_mem_alu_q, ex_mem_alu_d, ex_mem_sd_q, ex_mem_sd_d;
    mem_wb_t           mem_wb_q, mem_wb_d;
    logic [DATA_W-1:0] mem_wb_res_q, mem_wb_res_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] rf [NUM_REGS];

    id_ex_t            id_dec;
    logic [DATA_W-1:0] id_a, id_b;
    logic [DATA_W-1:0] op_a, op_b, alu_b, alu_res, imm_x;
    logic [ADDR_W-1:0] br_target;
    logic              br_taken;
    fwd_sel_e          fwd_a_c, fwd_b_c;
    logic              stall_c, flush_c, halt_c;

    // ID: decode and register read with write-through from WB.
    always_comb begin : id_stage
        id_dec = decode(if_id_q.instr);
        if (!if_id_q.valid) begin
            id_dec = '0;
        end
        id_a = rf[id_dec.ra];
        id_b = rf[id_dec.rb];
        if (mem_wb_q.we && (mem_wb_q.dst == id_dec.ra)) id_a = mem_wb_res_q;
        if (mem_wb_q.we && (mem_wb_q.dst == id_dec.rb)) id_b = mem_wb_res_q;
        if (id_dec.ra == '0) id_a = '0;
        if (id_dec.rb == '0) id_b = '0;
    end

    // EX: operand forwarding, ALU and branch resolution.
    always_comb begin : ex_stage
        case (fwd_a_c)
            FWD_MEM: op_a = ex_mem_alu_q;
            FWD_WB:  op_a = mem_wb_res_q;
            default: op_a = id_ex_a_q;
        endcase
        case (fwd_b_c)
            FWD_MEM: op_b = ex_mem_alu_q;
            FWD_WB:  op_b = mem_wb_res_q;
            default: op_b = id_ex_b_q;
        endcase
        imm_x = DATA_W'($signed(id_ex_q.imm));
        alu_b = id_ex_q.use_imm ? imm_x : op_b;
        case (id_ex_q.alu_op)
            ALU_SUB: alu_res = op_a - alu_b;
            ALU_AND: alu_res = op_a & alu_b;
            ALU_OR:  alu_res = op_a | alu_b;
            default: alu_res = op_a + alu_b;
        endcase
        br_taken  = id_ex_q.is_b ||
                    (id_ex_q.is_beq && (op_a == op_b)) ||
                    (id_ex_q.is_bne && (op_a != op_b));
        br_target = id_ex_pc_q + ADDR_W'($signed(id_ex_q.imm));
    end

    hazard_unit #(
        .FORWARD_EN (FORWARD_EN)
    ) u_hazard (
        .id_ra       (id_dec.ra),
        .id_rb       (id_dec.rb),
        .id_use_ra   (id_dec.use_ra),
        .id_use_rb   (id_dec.use_rb),
        .ex_ra       (id_ex_q.ra),
        .ex_rb       (id_ex_q.rb),
        .ex_use_ra   (id_ex_q.use_ra),
        .ex_use_rb   (id_ex_q.use_rb),
        .ex_dst      (id_ex_q.dst),
        .ex_we       (id_ex_q.we),
        .ex_is_load  (id_ex_q.is_load),
        .mem_dst     (ex_mem_q.dst),
        .mem_we      (ex_mem_q.we),
        .mem_is_load (ex_mem_q.is_load),
        .wb_dst      (mem_wb_q.dst),
        .wb_we       (mem_wb_q.we),
        .br_taken    (br_taken),
        .ex_halt     (id_ex_q.is_halt),
        .fwd_a_c     (fwd_a_c),
        .fwd_b_c     (fwd_b_c),
        .stall_c     (stall_c),
        .flush_c     (flush_c),
        .halt_c      (halt_c)
    );

    // Next-state for PC and pipe registers; MEM and WB always drain.
    always_comb begin : next_state
        pc_d         = pc_q;
        if_id_d      = if_id_q;
        if_id_pc_d   = if_id_pc_q;
        id_ex_d      = id_dec;
        id_ex_pc_d   = if_id_pc_q;
        id_ex_a_d    = id_a;
        id_ex_b_d    = id_b;
        halted_d     = halted_q;

        ex_mem_d.dst      = id_ex_q.dst;
        ex_mem_d.we       = id_ex_q.we;
        ex_mem_d.is_load  = id_ex_q.is_load;
        ex_mem_d.is_store = id_ex_q.is_store;
        ex_mem_alu_d      = alu_res;
        ex_mem_sd_d       = op_b;

        mem_wb_d.dst = ex_mem_q.dst;
        mem_wb_d.we  = ex_mem_q.we;
        mem_wb_res_d = ex_mem_q.is_load ? mem_if.data_mem_out_data_i : ex_mem_alu_q;

        if (halted_q || flush_c) begin
            // Redirect or halt: squash the two younger stages.
            if_id_d   = '{valid: 1'b0, instr: NOP_INSTR};
            id_ex_d   = '0;
            id_ex_a_d = '0;
            id_ex_b_d = '0;
            if (halt_c) begin
                halted_d = 1'b1;
            end else if (!halted_q) begin
                pc_d = br_target;
            end
        end else if (stall_c) begin
            id_ex_d   = '0;
            id_ex_a_d = '0;
            id_ex_b_d = '0;
        end else begin
            pc_d       = pc_q + ADDR_W'(1);
            if_id_d    = '{valid: 1'b1, instr: mem_if.inst_mem_data_i};
            if_id_pc_d = pc_q;
        end
    end

    // Pipe and PC registers.
    always_ff @(posedge CLK or negedge RST_N) begin : pipe_regs
        if (!RST_N) begin
            pc_q         <= RESET_PC;
            if_id_q      <= '{valid: 1'b0, instr: NOP_INSTR};
            if_id_pc_q   <= '0;
            id_ex_q      <= '0;
            id_ex_pc_q   <= '0;
            id_ex_a_q    <= '0;
            id_ex_b_q    <= '0;
            ex_mem_q     <= '0;
            ex_mem_alu_q <= '0;
            ex_mem_sd_q  <= '0;
            mem_wb_q     <= '0;
            mem_wb_res_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            if_id_q      <= if_id_d;
            if_id_pc_q   <= if_id_pc_d;
            id_ex_q      <= id_ex_d;
            id_ex_pc_q   <= id_ex_pc_d;
            id_ex_a_q    <= id_ex_a_d;
            id_ex_b_q    <= id_ex_b_d;
            ex_mem_q     <= ex_mem_d;
            ex_mem_alu_q <= ex_mem_alu_d;
            ex_mem_sd_q  <= ex_mem_sd_d;
            mem_wb_q     <= mem_wb_d;
            mem_wb_res_q <= mem_wb_res_d;
            halted_q     <= halted_d;
        end
    end

    // Register file; r0 is never written.
    always_ff @(posedge CLK or negedge RST_N) begin : reg_file
        if (!RST_N) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf[i] <= '0;
            end
        end else if (mem_wb_q.we && (mem_wb_q.dst != '0)) begin
            rf[mem_wb_q.dst] <= mem_wb_res_q;
        end
    end

    assign mem_if.inst_mem_address_o = pc_q;
    assign mem_if.data_mem_address_o = ADDR_W'(ex_mem_alu_q);
    assign mem_if.data_mem_in_data_o = ex_mem_sd_q;
    assign mem_if.data_mem_WE_o      = ex_mem_q.is_store;
    assign mem_if.halted_o           = halted_q;

endmodule

// File: tb/tb_cpu_pipeline_fwd.sv
// Directed bench for cpu_pipeline_fwd: one core with forwarding and one
// without, sharing the instruction memory and each with its own data memory.
module tb_cpu_pipeline_fwd;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_dmem = 1'b0;

    always #5 clk = ~clk;

    cpu_pipeline_fwd_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    cpu_pipeline_fwd_if #(.DATA_W(32), .ADDR_W(32)) bus_nf ();

    cpu_pipeline_fwd #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0), .FORWARD_EN(1'b1)) dut (
        .CLK(clk), .RST_N(rst_n), .mem_if(bus));
    cpu_pipeline_fwd #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0), .FORWARD_EN(1'b0)) dut_nf (
        .CLK(clk), .RST_N(rst_n), .mem_if(bus_nf));

    logic [31:0] imem      [64];
    logic [31:0] dmem_init [64];
    logic [31:0] dmem      [64];
    logic [31:0] dmem_nf   [64];

    assign bus.inst_mem_data_i        = imem[bus.inst_mem_address_o[5:0]];
    assign bus_nf.inst_mem_data_i     = imem[bus_nf.inst_mem_address_o[5:0]];
    assign bus.data_mem_out_data_i    = dmem[bus.data_mem_address_o[5:0]];
    assign bus_nf.data_mem_out_data_i = dmem_nf[bus_nf.data_mem_address_o[5:0]];

    always @(posedge clk) begin
        if (load_dmem) dmem <= dmem_init;
        else if (bus.data_mem_WE_o) dmem[bus.data_mem_address_o[5:0]] <= bus.data_mem_in_data_o;
    end
    always @(posedge clk) begin
        if (load_dmem) dmem_nf <= dmem_init;
        else if (bus_nf.data_mem_WE_o) dmem_nf[bus_nf.data_mem_address_o[5:0]] <= bus_nf.data_mem_in_data_o;
    end

    int checks = 0;
    int failures = 0;
    int edge_no;
    int we_first, we_cnt, we_first_nf, we_cnt_nf;
    logic [31:0] we_addr, we_data, we_data_nf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            imem[i]      = NOP_INSTR;
            dmem_init[i] = 32'h0;
        end
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        load_dmem = 1'b1;
        @(posedge clk); #1;
        load_dmem = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        edge_no = 0;
        we_first = -1; we_cnt = 0; we_first_nf = -1; we_cnt_nf = 0;
        we_addr = '0; we_data = '0; we_data_nf = '0;
    endtask

    // One clock; record the first store of each core and count strobes.
    task automatic step();
        @(posedge clk); #1;
        edge_no++;
        if (bus.data_mem_WE_o) begin
            if (we_cnt == 0) begin
                we_first = edge_no;
                we_addr  = bus.data_mem_address_o;
                we_data  = bus.data_mem_in_data_o;
            end
            we_cnt++;
        end
        if (bus_nf.data_mem_WE_o) begin
            if (we_cnt_nf == 0) begin
                we_first_nf = edge_no;
                we_data_nf  = bus_nf.data_mem_in_data_o;
            end
            we_cnt_nf++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        // Reset values
        clear_prog();
        hold_reset();
        chk("rst_pc", bus.inst_mem_address_o, 32'h0);
        chk("rst_we", 32'(bus.data_mem_WE_o), 32'h0);
        chk("rst_daddr", bus.data_mem_address_o, 32'h0);
        chk("rst_ddata", bus.data_mem_in_data_o, 32'h0);
        chk("rst_halted", 32'(bus.halted_o), 32'h0);

        // Forward chain: ADDI r1=5; ADD r2=r1+r1; SUB r3=r2-r1; STR r3->[0]; HALT
        clear_prog();
        imem[0] = 32'h5010_0005;
        imem[1] = 32'h1112_0000;
        imem[2] = 32'h2213_0000;
        imem[3] = 32'h7030_0000;
        imem[4] = 32'hF000_0000;
        hold_reset();
        release_reset();
        run(20);
        chk("fwd_store_edge", 32'(we_first), 32'd6);
        chk("fwd_store_data", we_data, 32'd5);
        chk("fwd_store_addr", we_addr, 32'd0);
        chk("fwd_r3", dut.rf[3], 32'd5);
        chk("fwd_halt_pc", bus.inst_mem_address_o, 32'd6);
        chk("fwd_halted", 32'(bus.halted_o), 32'd1);
        chk("nofwd_store_edge", 32'(we_first_nf), 32'd12);
        chk("nofwd_store_data", we_data_nf, 32'd5);
        chk("nofwd_r3", dut_nf.rf[3], 32'd5);

        // Load-use: LDR r1=[r0+4]; ADD r2=r1+r1; STR r2->[8]; HALT
        clear_prog();
        dmem_init[4] = 32'h0000_1234;
        imem[0] = 32'h6010_0004;
        imem[1] = 32'h1112_0000;
        imem[2] = 32'h7020_0008;
        imem[3] = 32'hF000_0000;
        hold_reset();
        release_reset();
        run(15);
        chk("lu_store_edge", 32'(we_first), 32'd6);
        chk("lu_store_data", we_data, 32'h0000_2468);
        chk("lu_store_addr", we_addr, 32'd8);
        chk("lu_r2", dut.rf[2], 32'h0000_2468);
        chk("lu_dmem8", dmem[8], 32'h0000_2468);

        // Branch: BEQ r0,r0,+3 at PC 10; shadow STR and ADDI r5 must not execute
        clear_prog();
        imem[10] = 32'h9000_0003;
        imem[11] = 32'h7000_0001;
        imem[12] = 32'h5050_0001;
        imem[13] = 32'h5040_0002;
        imem[14] = 32'h7040_0003;
        imem[15] = 32'hF000_0000;
        hold_reset();
        release_reset();
        run(25);
        chk("br_store_count", 32'(we_cnt), 32'd1);
        chk("br_store_edge", 32'(we_first), 32'd17);
        chk("br_store_addr", we_addr, 32'd3);
        chk("br_store_data", we_data, 32'd2);
        chk("br_r5", dut.rf[5], 32'd0);
        chk("br_r4", dut.rf[4], 32'd2);

        // Store forwarding: ADDI r1=7; STR r1->[2]; HALT
        clear_prog();
        imem[0] = 32'h5010_0007;
        imem[1] = 32'h7010_0002;
        imem[2] = 32'hF000_0000;
        hold_reset();
        release_reset();
        run(10);
        chk("sf_store_edge", 32'(we_first), 32'd4);
        chk("sf_store_count", 32'(we_cnt), 32'd1);
        chk("sf_store_addr", we_addr, 32'd2);
        chk("sf_store_data", we_data, 32'd7);
        chk("sf_dmem2", dmem[2], 32'd7);

        // HALT: ADDI r1=1; HALT; ADDI r2=9; ADDI r3=3
        clear_prog();
        imem[0] = 32'h5010_0001;
        imem[1] = 32'hF000_0000;
        imem[2] = 32'h5020_0009;
        imem[3] = 32'h5030_0003;
        hold_reset();
        release_reset();
        run(3);
        chk("halt_pre_flag", 32'(bus.halted_o), 32'd0);
        chk("halt_pre_pc", bus.inst_mem_address_o, 32'd3);
        run(1);
        chk("halt_flag", 32'(bus.halted_o), 32'd1);
        chk("halt_pc", bus.inst_mem_address_o, 32'd3);
        run(8);
        chk("halt_pc_late", bus.inst_mem_address_o, 32'd3);
        chk("halt_r1", dut.rf[1], 32'd1);
        chk("halt_r2", dut.rf[2], 32'd0);
        chk("halt_r3", dut.rf[3], 32'd0);

        // Reset mid-run while a store sits in MEM
        clear_prog();
        imem[0] = 32'h5010_0007;
        imem[1] = 32'h7010_0002;
        imem[2] = 32'hF000_0000;
        hold_reset();
        release_reset();
        run(4);
        chk("mr_we_before", 32'(bus.data_mem_WE_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_we", 32'(bus.data_mem_WE_o), 32'd0);
        chk("mr_daddr", bus.data_mem_address_o, 32'd0);
        chk("mr_ddata", bus.data_mem_in_data_o, 32'd0);
        chk("mr_pc", bus.inst_mem_address_o, 32'd0);
        chk("mr_halted", 32'(bus.halted_o), 32'd0);
        @(posedge clk); #1;
        chk("mr_store_dropped", dmem[2], 32'd0);
        release_reset();
        run(1);
        chk("mr_refetch_pc", bus.inst_mem_address_o, 32'd1);
        run(5);
        chk("mr_rerun_edge", 32'(we_first), 32'd4);
        chk("mr_rerun_data", we_data, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
